// File: rtl/rf_ctrl_pkg.sv
// Shared register-file control types and constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rf_ctrl_pkg;

  localparam int RF_NUM_REGS = 16;
  localparam int RF_ID_W     = 4;
  localparam int RF_DATA_W   = 16;

  typedef logic [RF_ID_W-1:0]     rfId_t;
  typedef logic [RF_DATA_W-1:0]   rfData_t;
  typedef logic [RF_NUM_REGS-1:0] rfMask_t;

  // Round-robin requester identity; value is the favoured writeback source.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } rfReq_e;

  // One-hot mask for a register id, all-zero when not enabled.
  function automatic rfMask_t regMask(input rfId_t id, input logic en);
    rfMask_t m;
    m = '0;
    m[id] = en;
    return m;
  endfunction

endpackage

// File: rtl/rf_write_scheduler_if.sv
// Writeback request and destination-claim handshakes into the scheduler.
// Latency: n/a (wiring only).
// Backpressure: each ready is driven by the scheduler; requesters hold while ready=0.
interface rf_write_scheduler_if;
  import rf_ctrl_pkg::*;

  logic    alu_valid;
  rfId_t   alu_dst;
  rfData_t alu_data;
  logic    alu_ready;

  logic    mem_valid;
  rfId_t   mem_dst;
  rfData_t mem_data;
  logic    mem_ready;

  logic    alloc_valid;
  rfId_t   alloc_reg;
  logic    alloc_ready;

  // Requester side: execute, memory and issue stages.
  modport master (
    output alu_valid, alu_dst, alu_data,
    input  alu_ready,
    output mem_valid, mem_dst, mem_data,
    input  mem_ready,
    output alloc_valid, alloc_reg,
    input  alloc_ready
  );

  // Scheduler side.
  modport slave (
    input  alu_valid, alu_dst, alu_data,
    output alu_ready,
    input  mem_valid, mem_dst, mem_data,
    output mem_ready,
    input  alloc_valid, alloc_reg,
    output alloc_ready
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending-write bits with set and clear ports.
// Latency: set/clear visible on busy one cycle after the request edge.
// Backpressure: none; a same-cycle set and clear of one register leaves it set.
module rf_scoreboard
  import rf_ctrl_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                setVld,
  input  rfId_t               setReg,
  input  logic                clrVld,
  input  rfId_t               clrReg,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] setMask;
  logic [NUM_REGS-1:0] clrMask;

  // Decode the set and clear requests into one-hot masks.
  always_comb begin
    setMask = regMask(setReg, setVld);
    clrMask = regMask(clrReg, clrVld);
  end

  // Clear first, then OR in the set so a claim racing a writeback stays pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~clrMask) | setMask;
    end
  end

endmodule

// File: rtl/rf_write_scheduler.sv
// Arbitrates ALU/load writebacks onto the single RF write port and tracks pending registers.
// Latency: accept in cycle N -> WriteReg/DstReg/DstData in N+1; busy updates at the N edge.
// Backpressure: round-robin ready on conflict; loser holds. Optional bypass: RF_WB_BYPASS_EN.
module rf_write_scheduler
  import rf_ctrl_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int DATA_W   = RF_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  rf_write_scheduler_if.slave  wb,
  output logic                 WriteReg,
  output rfId_t                DstReg,
  output logic [DATA_W-1:0]    DstData,
  output logic [NUM_REGS-1:0]  busy
`ifdef RF_WB_BYPASS_EN
  ,
  input  rfId_t                rd_reg1,
  input  rfId_t                rd_reg2,
  output logic                 byp_hit1,
  output logic                 byp_hit2,
  output logic [DATA_W-1:0]    byp_data
`endif
);

  rfReq_e  fav;
  rfReq_e  favNext;
  logic    aluGrant;
  logic    memGrant;
  logic    wbAccept;
  rfId_t   wbDst;
  rfData_t wbData;
  logic    allocOk;
  logic    sbSet;
  logic    sbClr;

  // Round-robin pointer register; ALU is favoured out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fav <= REQ_ALU;
    end else begin
      fav <= favNext;
    end
  end

  // After any grant, favour the requester that was not served.
  always_comb begin
    favNext = fav;
    if (aluGrant) begin
      favNext = REQ_MEM;
    end else if (memGrant) begin
      favNext = REQ_ALU;
    end
  end

  // Grants: a lone requester always wins; on conflict the favoured one wins.
  always_comb begin
    aluGrant = wb.alu_valid && (!wb.mem_valid || (fav == REQ_ALU));
    memGrant = wb.mem_valid && (!wb.alu_valid || (fav == REQ_MEM));
    wbAccept = aluGrant || memGrant;
    wbDst    = aluGrant ? wb.alu_dst  : wb.mem_dst;
    wbData   = aluGrant ? wb.alu_data : wb.mem_data;
  end

  assign wb.alu_ready = aluGrant;
  assign wb.mem_ready = memGrant;

  // Register 0 is hardwired, so claims on it never block and never mark it pending.
  always_comb begin
    allocOk = !busy[wb.alloc_reg] || (wb.alloc_reg == '0);
    sbSet   = wb.alloc_valid && allocOk && (wb.alloc_reg != '0);
    sbClr   = wbAccept && (wbDst != '0);
  end

  assign wb.alloc_ready = allocOk;

  // Output stage: a write to r0 is swallowed; index/data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      WriteReg <= 1'b0;
      DstReg   <= '0;
      DstData  <= '0;
    end else begin
      WriteReg <= wbAccept && (wbDst != '0);
      if (wbAccept) begin
        DstReg  <= wbDst;
        DstData <= wbData;
      end
    end
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk    (clk),
    .rst    (rst),
    .setVld (sbSet),
    .setReg (wb.alloc_reg),
    .clrVld (sbClr),
    .clrReg (wbDst),
    .busy   (busy)
  );

`ifdef RF_WB_BYPASS_EN
  // Forward the write in flight so readers in the write cycle see new data.
  always_comb begin
    byp_hit1 = WriteReg && (DstReg == rd_reg1) && (rd_reg1 != '0);
    byp_hit2 = WriteReg && (DstReg == rd_reg2) && (rd_reg2 != '0);
    byp_data = DstData;
  end
`endif

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Self-checking bench for rf_write_scheduler: vector table plus hand-written corner sequences.
// Latency: expected writes queued at drive time, compared one cycle later.
// Backpressure: readiness expectations are written into each vector.
module tb_rf_write_scheduler;

  logic        clk;
  logic        rst;
  logic        WriteReg;
  logic [3:0]  DstReg;
  logic [15:0] DstData;
  logic [15:0] busy;
`ifdef RF_WB_BYPASS_EN
  logic [3:0]  rd_reg1;
  logic [3:0]  rd_reg2;
  logic        byp_hit1;
  logic        byp_hit2;
  logic [15:0] byp_data;
`endif

  rf_write_scheduler_if wbIf ();

  rf_write_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .wb       (wbIf.slave),
    .WriteReg (WriteReg),
    .DstReg   (DstReg),
    .DstData  (DstData),
    .busy     (busy)
`ifdef RF_WB_BYPASS_EN
    ,
    .rd_reg1  (rd_reg1),
    .rd_reg2  (rd_reg2),
    .byp_hit1 (byp_hit1),
    .byp_hit2 (byp_hit2),
    .byp_data (byp_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        aluV;
    logic [3:0]  aluDst;
    logic [15:0] aluData;
    logic        memV;
    logic [3:0]  memDst;
    logic [15:0] memData;
    logic        allocV;
    logic [3:0]  allocReg;
    logic        expAluRdy;
    logic        expMemRdy;
    logic        expAllocRdy;
    logic [15:0] expBusy;
  } vec_t;

  typedef struct {
    logic        we;
    logic [3:0]  dst;
    logic [15:0] data;
  } wr_t;

  wr_t  expQ[$];
  vec_t vecs[18];
  int   nChecks = 0;
  int   nFails  = 0;

  function automatic vec_t mk(input logic aV, input logic [3:0] aD, input logic [15:0] aX,
                              input logic mV, input logic [3:0] mD, input logic [15:0] mX,
                              input logic lV, input logic [3:0] lR,
                              input logic eA, input logic eM, input logic eL,
                              input logic [15:0] eB);
    vec_t v;
    v.aluV = aV; v.aluDst = aD; v.aluData = aX;
    v.memV = mV; v.memDst = mD; v.memData = mX;
    v.allocV = lV; v.allocReg = lR;
    v.expAluRdy = eA; v.expMemRdy = eM; v.expAllocRdy = eL;
    v.expBusy = eB;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic setInputs(input vec_t v);
    wbIf.alu_valid   = v.aluV;
    wbIf.alu_dst     = v.aluDst;
    wbIf.alu_data    = v.aluData;
    wbIf.mem_valid   = v.memV;
    wbIf.mem_dst     = v.memDst;
    wbIf.mem_data    = v.memData;
    wbIf.alloc_valid = v.allocV;
    wbIf.alloc_reg   = v.allocReg;
  endtask

  // Pop the write expected for the cycle just completed and compare the output stage.
  task automatic checkOut(input string tag);
    wr_t e;
    nChecks++;
    if (expQ.size() == 0) begin
      nFails++;
      $display("FAIL %s_queue: got empty scoreboard, expected one entry", tag);
    end else begin
      nChecks--;
      e = expQ.pop_front();
      check({tag, "_WriteReg"}, WriteReg, e.we);
      if (e.we) begin
        check({tag, "_DstReg"}, DstReg, e.dst);
        check({tag, "_DstData"}, DstData, e.data);
      end
    end
  endtask

  // One cycle: drive at negedge, check readies, queue expected write, check after the edge.
  task automatic driveVec(input string tag, input vec_t v);
    wr_t e;
    @(negedge clk);
    setInputs(v);
    #1;
    check({tag, "_alu_ready"}, wbIf.alu_ready, v.expAluRdy);
    check({tag, "_mem_ready"}, wbIf.mem_ready, v.expMemRdy);
    check({tag, "_alloc_ready"}, wbIf.alloc_ready, v.expAllocRdy);
    e.we = 1'b0; e.dst = 4'd0; e.data = 16'd0;
    if (v.expAluRdy) begin
      e.we = (v.aluDst != 4'd0); e.dst = v.aluDst; e.data = v.aluData;
    end else if (v.expMemRdy) begin
      e.we = (v.memDst != 4'd0); e.dst = v.memDst; e.data = v.memData;
    end
    expQ.push_back(e);
    @(posedge clk);
    #1;
    checkOut(tag);
    check({tag, "_busy"}, busy, v.expBusy);
  endtask

  initial begin
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000);

    //          aluV dst data     memV dst data     lV reg  eA eM eL busy
    vecs[0]  = mk(1, 3, 16'h1234, 0, 0, 16'h0000, 0, 0,   1, 0, 1, 16'h0000);
    vecs[1]  = mk(0, 0, 16'h0000, 1, 2, 16'h0202, 0, 0,   0, 1, 1, 16'h0000);
    vecs[2]  = mk(1, 5, 16'hAAAA, 1, 6, 16'h5555, 0, 0,   1, 0, 1, 16'h0000);
    vecs[3]  = mk(0, 0, 16'h0000, 1, 6, 16'h5555, 0, 0,   0, 1, 1, 16'h0000);
    vecs[4]  = mk(1, 8, 16'h0808, 1, 10, 16'h0A0A, 0, 0,  1, 0, 1, 16'h0000);
    vecs[5]  = mk(0, 0, 16'h0000, 1, 10, 16'h0A0A, 0, 0,  0, 1, 1, 16'h0000);
    vecs[6]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 7,   0, 0, 1, 16'h0080);
    vecs[7]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 7,   0, 0, 0, 16'h0080);
    vecs[8]  = mk(0, 0, 16'h0000, 1, 7, 16'h7777, 1, 7,   0, 1, 0, 16'h0000);
    vecs[9]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 7,   0, 0, 1, 16'h0080);
    vecs[10] = mk(1, 9, 16'h9999, 0, 0, 16'h0000, 1, 9,   1, 0, 1, 16'h0280);
    vecs[11] = mk(1, 9, 16'h1999, 0, 0, 16'h0000, 0, 0,   1, 0, 1, 16'h0080);
    vecs[12] = mk(1, 0, 16'hFFFF, 0, 0, 16'h0000, 1, 0,   1, 0, 1, 16'h0080);
    vecs[13] = mk(0, 0, 16'h0000, 1, 12, 16'hC0DE, 0, 0,  0, 1, 1, 16'h0080);
    vecs[14] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 7,   0, 0, 0, 16'h0080);
    vecs[15] = mk(1, 7, 16'h0777, 1, 1, 16'h0111, 0, 0,   1, 0, 1, 16'h0000);
    vecs[16] = mk(1, 2, 16'h2222, 1, 1, 16'h0111, 0, 0,   0, 1, 1, 16'h0000);
    vecs[17] = mk(1, 2, 16'h2222, 0, 0, 16'h0000, 0, 0,   1, 0, 1, 16'h0000);

    rst = 1'b1;
    setInputs(idle);
`ifdef RF_WB_BYPASS_EN
    rd_reg1 = 4'd0;
    rd_reg2 = 4'd0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_WriteReg", WriteReg, 1'b0);
    check("rst_DstReg", DstReg, 4'd0);
    check("rst_DstData", DstData, 16'h0000);
    check("rst_busy", busy, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_alu_ready", wbIf.alu_ready, 1'b0);
    check("rst_mem_ready", wbIf.mem_ready, 1'b0);
    check("rst_alloc_ready", wbIf.alloc_ready, 1'b1);

    for (int i = 0; i < 18; i++) begin
      driveVec($sformatf("v%0d", i), vecs[i]);
    end

    // Idle cycles: index and data must hold the last accepted write.
    driveVec("hold0", idle);
    check("hold0_DstReg", DstReg, 4'd2);
    check("hold0_DstData", DstData, 16'h2222);
    driveVec("hold1", idle);
    check("hold1_DstReg", DstReg, 4'd2);
    check("hold1_DstData", DstData, 16'h2222);

    // Reset mid-operation: pending bit and in-flight write are lost, pointer returns to ALU.
    driveVec("mr_alloc", mk(0, 0, 16'h0, 0, 0, 16'h0, 1, 5, 0, 0, 1, 16'h0020));
    driveVec("mr_wb", mk(1, 3, 16'h3333, 0, 0, 16'h0, 0, 0, 1, 0, 1, 16'h0020));
    @(negedge clk);
    rst = 1'b1;
    setInputs(mk(1, 11, 16'hBBBB, 1, 13, 16'hDDDD, 1, 6, 0, 0, 0, 16'h0));
    @(posedge clk);
    #1;
    check("mr_WriteReg", WriteReg, 1'b0);
    check("mr_DstReg", DstReg, 4'd0);
    check("mr_DstData", DstData, 16'h0000);
    check("mr_busy", busy, 16'h0000);
    rst = 1'b0;
    driveVec("mr_fav", mk(1, 11, 16'hBBBB, 1, 13, 16'hDDDD, 0, 0, 1, 0, 1, 16'h0000));

`ifdef RF_WB_BYPASS_EN
    // Bypass of the write in flight.
    driveVec("byp_wb", mk(0, 0, 16'h0, 1, 4, 16'hBEEF, 0, 0, 0, 1, 1, 16'h0000));
    rd_reg1 = 4'd4;
    rd_reg2 = 4'd5;
    #1;
    check("byp_hit1", byp_hit1, 1'b1);
    check("byp_hit2", byp_hit2, 1'b0);
    check("byp_data", byp_data, 16'hBEEF);
    rd_reg2 = 4'd0;
    #1;
    check("byp_hit2_r0", byp_hit2, 1'b0);

    // Reset in the write cycle drops the following write and any bypass hit.
    driveVec("byp_rwb", mk(0, 0, 16'h0, 1, 4, 16'h4444, 0, 0, 0, 1, 1, 16'h0000));
    @(negedge clk);
    rst = 1'b1;
    setInputs(mk(0, 0, 16'h0, 1, 4, 16'h5555, 0, 0, 0, 0, 0, 16'h0));
    @(posedge clk);
    #1;
    check("byp_rst_WriteReg", WriteReg, 1'b0);
    check("byp_rst_hit1", byp_hit1, 1'b0);
    rst = 1'b0;
    setInputs(idle);
`endif

    check("queue_drained", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
